kf_sub_sequencer: RTL and testbench

Operand-issue and result-collection stage wrapped around the floating-point subtractor wrapper in the Kalman update datapath (innovation z − Hx, covariance P − KHP).
- Accepts IEEE-754 single-precision operand pairs over a ready/valid handshake and drives the subtractor wrapper's operand and valid inputs.
- Tracks in-flight operations with a valid delay line matched to the wrapper's fixed latency, since the wrapper exposes no result valid.
- Captures results into an output FIFO and presents them downstream with ready/valid, using credit-based backpressure so no result is ever dropped.

---
 rtl/kf_sub_sequencer.sv | 123 ++++++++++++
 tb/tb_kf_sub_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_sub_sequencer.sv
// Operand issue, latency-matched valid tracking and credit-gated FWFT result FIFO
// around the float32 subtractor wrapper. Optional tag path: define KF_SUB_TAG_EN.
module kf_sub_sequencer #(
  parameter int LAT   = 12,
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [31:0]            sub_dataa,
  output logic [31:0]            sub_datab,
  output logic                   sub_validdataa,
  output logic                   sub_validdatab,
  input  logic [31:0]            sub_result,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] credits_used,
`ifdef KF_SUB_TAG_EN
  input  logic [TAG_W-1:0]       in_tag,
  output logic [TAG_W-1:0]       out_tag,
`endif
  output logic                   err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (LAT < 2 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W < 1) begin : g_bad_params
    $error("kf_sub_sequencer: need LAT>=2, DEPTH>=4 and a power of two, TAG_W>=1");
  end

  logic          accept;
  logic          pop;
  logic          cap_vld_p2;
  logic          full;
  logic          push;
  logic [LAT-1:0] vld_p1;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   data_mem [DEPTH];

  // Credits cover in-flight ops too, so a full FIFO normally cannot see a capture.
  assign in_ready       = !reset && (credits_used < DEPTH_C);
  assign accept         = in_valid && in_ready;
  assign out_valid      = (fifo_cnt != '0);
  assign pop            = out_valid && out_ready;
  assign cap_vld_p2     = vld_p1[LAT-1];
  assign full           = (fifo_cnt == DEPTH_C);
  assign push           = cap_vld_p2 && (!full || pop);
  assign sub_validdatab = sub_validdataa;
  assign out_data       = out_valid ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      sub_dataa      <= '0;
      sub_datab      <= '0;
      sub_validdataa <= 1'b0;
      vld_p1         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      credits_used   <= '0;
      err_ovf        <= 1'b0;
    end else begin
      // stage p0: operand issue to the wrapper
      sub_validdataa <= accept;
      if (accept) begin
        sub_dataa <= in_a;
        sub_datab <= in_b;
      end
      // stage p1: valid delay line matched to the wrapper latency
      vld_p1 <= {vld_p1[LAT-2:0], sub_validdataa};
      // stage p2: result capture and FIFO bookkeeping
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   credits_used <= credits_used + 1'b1;
        2'b01:   credits_used <= credits_used - 1'b1;
        default: credits_used <= credits_used;
      endcase
      if (cap_vld_p2 && full && !pop) err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) data_mem[wr_ptr] <= sub_result;
  end

`ifdef KF_SUB_TAG_EN
  logic [TAG_W-1:0]          tag_p0;
  logic [LAT-1:0][TAG_W-1:0] tag_p1;
  logic [TAG_W-1:0]          tag_mem [DEPTH];

  assign out_tag = out_valid ? tag_mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_p0 <= '0;
      tag_p1 <= '0;
    end else begin
      if (accept) tag_p0 <= in_tag;
      tag_p1 <= {tag_p1[LAT-2:0], tag_p0};
    end
  end

  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= tag_p1[LAT-1];
  end
`endif

endmodule

// File: tb/tb_kf_sub_sequencer.sv
// Self-checking bench for kf_sub_sequencer: vector table, corner sequences and
// randomized traffic against a queue-based reference model plus a wrapper model.
`timescale 1ns/1ps
module tb_kf_sub_sequencer;
  localparam int LAT   = 12;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      in_a = '0, in_b = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      sub_dataa, sub_datab;
  logic             sub_validdataa, sub_validdatab;
  logic [31:0]      sub_result;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       credits_used;
  logic             err_ovf;
  logic [TAG_W-1:0] in_tag = '0;
`ifdef KF_SUB_TAG_EN
  logic [TAG_W-1:0] out_tag;
`endif

  int total = 0;
  int bad   = 0;

  kf_sub_sequencer #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .sub_dataa(sub_dataa), .sub_datab(sub_datab),
    .sub_validdataa(sub_validdataa), .sub_validdatab(sub_validdatab),
    .sub_result(sub_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .credits_used(credits_used),
`ifdef KF_SUB_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  // Integer-valued float32 helpers (|n| < 2^24).
  function automatic logic [31:0] i2f(int n);
    int m;
    int p;
    if (n == 0) return 32'h0;
    m = (n < 0) ? -n : n;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    return {(n < 0), 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int f2i(logic [31:0] f);
    int e;
    int mant;
    int v;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    mant = int'({1'b1, f[22:0]});
    v = (e >= 150) ? (mant << (e - 150)) : (mant >> (150 - e));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] fsub(logic [31:0] a, logic [31:0] b);
    return i2f(f2i(a) - f2i(b));
  endfunction

  // Subtractor wrapper model: fixed latency, garbage when no valid was presented.
  logic [LAT-1:0][31:0] wp;
  always @(posedge clock)
    wp <= {wp[LAT-2:0], sub_validdataa ? fsub(sub_dataa, sub_datab) : 32'hDEAD_BEEF};
  assign sub_result = wp[LAT-1];

  // Reference model: each accepted pair becomes visible LAT+1 edges after its accept.
  logic [31:0]      q_data[$];
  int               q_vis[$];
  logic [TAG_W-1:0] q_tag[$];
  int               cyc = 0;

  initial forever begin
    int n_before;
    @(posedge clock);
    if (reset) begin
      q_data.delete(); q_vis.delete(); q_tag.delete();
    end else begin
      n_before = q_data.size();
      if (n_before > 0 && q_vis[0] <= cyc && out_ready) begin
        void'(q_data.pop_front()); void'(q_vis.pop_front()); void'(q_tag.pop_front());
      end
      if (in_valid && n_before < DEPTH) begin
        q_data.push_back(fsub(in_a, in_b));
        q_vis.push_back(cyc + 2 + LAT);
        q_tag.push_back(in_tag);
      end
    end
    cyc++;
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Continuous monitor on the falling edge; also records every pop for order checks.
  logic        mon_en = 1'b0;
  logic [31:0] got[$];
  int          got_cyc[$];

  initial forever begin
    logic exp_v;
    @(negedge clock);
    if (mon_en) begin
      exp_v = (q_vis.size() > 0) && (q_vis[0] <= cyc);
      check("mon in_ready", 32'(in_ready), 32'(!reset && q_data.size() < DEPTH));
      check("mon out_valid", 32'(out_valid), 32'(exp_v));
      check("mon credits_used", 32'(credits_used), 32'(q_data.size()));
      check("mon err_ovf", 32'(err_ovf), 32'd0);
      check("mon validdatab", 32'(sub_validdatab), 32'(sub_validdataa));
      if (exp_v) begin
        check("mon out_data", out_data, q_data[0]);
`ifdef KF_SUB_TAG_EN
        check("mon out_tag", 32'(out_tag), 32'(q_tag[0]));
`endif
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[6];
  int   acc;
  int   w;

  initial begin
    tv[0] = '{32'h40A00000, 32'h40400000, 32'h40000000};  //   5 - 3   = 2
    tv[1] = '{32'h40400000, 32'h40A00000, 32'hC0000000};  //   3 - 5   = -2
    tv[2] = '{32'h41200000, 32'h00000000, 32'h41200000};  //  10 - 0   = 10
    tv[3] = '{32'h00000000, 32'h00000000, 32'h00000000};  //   0 - 0   = 0
    tv[4] = '{32'h42C80000, 32'h3F800000, 32'h42C60000};  // 100 - 1   = 99
    tv[5] = '{32'h3F800000, 32'hBF800000, 32'h40000000};  //   1 - -1  = 2

    repeat (3) tick();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst sub_dataa", sub_dataa, 32'd0);
    check("rst sub_datab", sub_datab, 32'd0);
    check("rst sub_valid", 32'(sub_validdataa), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst credits", 32'(credits_used), 32'd0);
    check("rst err_ovf", 32'(err_ovf), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Single ops from the vector table, with exact latency checks.
    for (int i = 0; i < 6; i++) begin
      in_a = tv[i].a; in_b = tv[i].b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("tbl sub_valid", 32'(sub_validdataa), 32'd1);
      check("tbl sub_dataa", sub_dataa, tv[i].a);
      check("tbl sub_datab", sub_datab, tv[i].b);
      tick();
      check("tbl sub_valid low", 32'(sub_validdataa), 32'd0);
      repeat (LAT - 1) tick();
      check("tbl early valid", 32'(out_valid), 32'd0);
      tick();
      check("tbl out_valid", 32'(out_valid), 32'd1);
      check("tbl out_data", out_data, tv[i].exp);
      check("tbl credits 1", 32'(credits_used), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("tbl credits 0", 32'(credits_used), 32'd0);
      check("tbl popped", 32'(out_valid), 32'd0);
    end

    // Stream of 20 back-to-back ops with out_ready held high.
    got.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = i2f(i + 1); in_b = i2f(1); in_tag = TAG_W'(i); in_valid = 1'b1;
      check("stream in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 4) tick();
    check("stream count", 32'(got.size()), 32'd20);
    for (int i = 0; i < got.size() && i < 20; i++) begin
      check("stream data", got[i], i2f(i));
      check("stream gap", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end

    // Backpressure: only DEPTH of 20 offered pairs may be accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_a = i2f(1000 + 3 * acc); in_b = i2f(acc); in_tag = TAG_W'(acc); in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp accepted", 32'(acc), 32'd16);
    check("bp credits", 32'(credits_used), 32'd16);
    check("bp in_ready", 32'(in_ready), 32'd0);
    repeat (LAT + 2) tick();
    check("bp full valid", 32'(out_valid), 32'd1);
    check("bp head", out_data, i2f(1000));
    check("bp err_ovf", 32'(err_ovf), 32'd0);

    // Offer and pop together at the credit limit, then accept+pop with credits steady.
    got.delete(); got_cyc.delete();
    in_a = i2f(7); in_b = i2f(2); in_valid = 1'b1; out_ready = 1'b1;
    check("lim in_ready low", 32'(in_ready), 32'd0);
    tick();
    check("lim head advance", out_data, i2f(1002));
    check("lim credits 15", 32'(credits_used), 32'd15);
    check("lim in_ready back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("acc+pop credits", 32'(credits_used), 32'd15);
    check("acc+pop head", out_data, i2f(1004));
    w = 0;
    while ((credits_used != 0 || out_valid) && w < 80) begin
      tick();
      w++;
    end
    check("drain done", 32'(credits_used == 0 && !out_valid), 32'd1);
    check("drain count", 32'(got.size()), 32'd17);
    for (int i = 0; i < got.size() && i < 16; i++)
      check("drain order", got[i], i2f(1000 + 2 * i));
    if (got.size() == 17) check("drain last", got[16], i2f(5));
    check("drain in_ready", 32'(in_ready), 32'd1);

    // Reset with 5 ops in flight: late wrapper results must be ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_a = i2f(50 + i); in_b = i2f(1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    check("mid rst credits", 32'(credits_used), 32'd0);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out_data", out_data, 32'd0);
    check("mid rst sub_valid", 32'(sub_validdataa), 32'd0);
    check("mid rst sub_dataa", sub_dataa, 32'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("mid rst no spurious", 32'(out_valid), 32'd0);
    end
    check("mid rst credits after", 32'(credits_used), 32'd0);

    // Randomized traffic checked continuously by the monitor.
    for (int i = 0; i < 400; i++) begin
      in_a = i2f(int'($urandom_range(0, 2000)) - 1000);
      in_b = i2f(int'($urandom_range(0, 2000)) - 1000);
      in_tag = TAG_W'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while ((credits_used != 0 || out_valid) && w < 100) begin
      tick();
      w++;
    end
    check("rand drained", 32'(credits_used == 0 && !out_valid), 32'd1);
    check("final err_ovf", 32'(err_ovf), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
